// File: rtl/ams_pwm_gen.sv
// ams_pwm_gen: turns a 24-bit AMS DAC setting into a PWM stream. The setting is shadowed at frame boundaries.
// Optional dither of the 16-bit low field over a 16-period frame is enabled by defining AMS_PWM_DITHER_EN.
module ams_pwm_gen #(
  parameter int unsigned CCW  = 8,
  parameter int unsigned FULL = 155
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] cfg_i,
  output logic        pwm_o,
  output logic        frame_o
);

  logic [CCW-1:0] r_v;
  logic [3:0]     r_b;
  logic [7:0]     r_base;
`ifdef AMS_PWM_DITHER_EN
  logic [15:0]    r_mask;
`endif
  logic           w_last;
  logic           w_load;
  logic [8:0]     w_d;

  assign w_last = (r_v == CCW'(FULL));
  assign w_load = w_last && (r_b == 4'd15);

  // The duty is 9 bits wide, so a base of 255 plus a dither bit reaches 256 without wrapping.
`ifdef AMS_PWM_DITHER_EN
  assign w_d = {1'b0, r_base} + {8'd0, r_mask[r_b]};
`else
  assign w_d = {1'b0, r_base};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v     <= '0;
      r_b     <= '0;
      pwm_o   <= 1'b0;
      frame_o <= 1'b0;
      r_base  <= cfg_i[23:16];
`ifdef AMS_PWM_DITHER_EN
      r_mask  <= cfg_i[15:0];
`endif
    end else begin
      r_v     <= w_last ? '0 : r_v + CCW'(1);
      if (w_last) r_b <= r_b + 4'd1;
      pwm_o   <= (32'(r_v) < 32'(w_d));
      frame_o <= w_load;
      if (w_load) begin
        r_base <= cfg_i[23:16];
`ifdef AMS_PWM_DITHER_EN
        r_mask <= cfg_i[15:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_ams_pwm_gen.sv
// Scoreboard bench for ams_pwm_gen: stimulus pushes the expected high count per period,
// and a monitor measures each 156-cycle period and also checks its shape and frame strobe.
module tb_ams_pwm_gen;

  localparam int PER = 156;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [23:0] cfg_i = '0;
  logic        pwm_o;
  logic        frame_o;

  int n_chk  = 0;
  int n_pass = 0;
  int q[$];

  ams_pwm_gen #(.CCW(8), .FULL(155)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .cfg_i  (cfg_i),
    .pwm_o  (pwm_o),
    .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  // Monitor: the outputs seen at a negedge belong to the posedge just before it.
  logic prev_rst = 1'b1;
  int   pos = 0, hi = 0, per = 0, shape_err = 0, frame_err = 0, exp_d = 0;
  always @(negedge clk) begin
    if (prev_rst) begin
      n_chk++;
      if (pwm_o === 1'b0 && frame_o === 1'b0) n_pass++;
      else $display("FAIL reset_state: pwm_o=%b frame_o=%b required 0/0", pwm_o, frame_o);
      pos = 0; hi = 0; per = 0; shape_err = 0; frame_err = 0;
    end else begin
      if (pwm_o === 1'b1) begin
        if (pos != hi) shape_err++;
        hi++;
      end else if (pwm_o !== 1'b0) shape_err++;
      if (frame_o !== ((pos == PER-1) && (per == 15))) frame_err++;
      pos++;
      if (pos == PER) begin
        if (q.size() != 0) begin
          exp_d = q.pop_front();
          n_chk++;
          if (hi == exp_d) n_pass++;
          else $display("FAIL period_high[%0d]: got %0d high cycles, required %0d", per, hi, exp_d);
          n_chk++;
          if (shape_err == 0) n_pass++;
          else $display("FAIL period_shape[%0d]: %0d high cycles after a low, required 0", per, shape_err);
          n_chk++;
          if (frame_err == 0) n_pass++;
          else $display("FAIL frame_strobe[%0d]: %0d wrong frame_o cycles, required 0", per, frame_err);
        end
        pos = 0; hi = 0; shape_err = 0; frame_err = 0;
        per = (per + 1) % 16;
      end
    end
    prev_rst = rst_i;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [23:0] cfg);
    cfg_i = cfg;
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
  endtask

  task automatic push(input int d, input int n);
    repeat (n) q.push_back(d);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL %s_timeout: %0d periods still pending, required 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    tick(3);

    // All-zero setting over three frames.
    do_reset(24'h000000);
    push(0, 48);
    wait_drain("zero", 49 * PER);

    // Base 156 keeps the output high for the whole period.
    do_reset(24'h9C0000);
    push(156, 16);
    wait_drain("full", 17 * PER);

    // Half duty, two frames.
    do_reset(24'h4E0000);
    push(78, 32);
    wait_drain("half", 33 * PER);

    // Single dither bit in period 0.
    do_reset(24'h0F0001);
`ifdef AMS_PWM_DITHER_EN
    push(16, 1);
    push(15, 15);
`else
    push(15, 16);
`endif
    wait_drain("dither", 17 * PER);

    // Mid-frame write only takes effect from period 0 of the next frame.
    do_reset(24'h0F0000);
    push(15, 16);
`ifdef AMS_PWM_DITHER_EN
    push(118, 4);
    push(117, 12);
`else
    push(117, 16);
`endif
    tick(5 * PER);
    cfg_i = 24'h75000F;
    wait_drain("shadow", 33 * PER);

    // One-cycle reset in the high phase of period 2 restarts with the new setting.
    do_reset(24'h4E0000);
    push(78, 2);
    tick(2 * PER + 30);
    cfg_i = 24'h200000;
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    push(32, 3);
    wait_drain("midreset", 4 * PER);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
